// File: rtl/mips_core.sv
// rtl/mips_core.sv - single-cycle 32-bit MIPS subset core with instruction ROM, register bank and data memory
//
// Purpose : executes one instruction per clock from a 32-word instruction
//           memory: R-type add/sub/and/or/slt, lw, sw, beq, addi and j.
//           Every other opcode behaves as a NOP.
// Ports   : clk   - clock; all state updates on its rising edge
//           reset - synchronous, active-high; clears PC, registers and data memory
// Config  : DMEM_BYTE_EN - when defined, data memory is 256 x 8-bit bytes and
//           lw/sw access four little-endian bytes that wrap within 256;
//           otherwise it is 256 x 32-bit words addressed by ALU result [9:2].

// Instruction memory: contents are preloaded from outside the design.
// Ports: addr - word index (PC[6:2]); instruction - fetched word.
module mips_instr_mem (
   input  logic [4:0]  addr,
   output logic [31:0] instruction
);
   logic [31:0] mem [0:31];

   assign instruction = mem[addr];
endmodule

// Register bank: two asynchronous read ports, one synchronous write port.
// Ports: clk, reset, we - write enable, rs_addr/rt_addr - read addresses,
//        wr_addr/wr_data - write port, rs_data/rt_data - read data.
module mips_reg_bank (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [4:0]  rs_addr,
   input  logic [4:0]  rt_addr,
   input  logic [4:0]  wr_addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rs_data,
   output logic [31:0] rt_data
);
   logic [31:0] registers [0:31];

   // Register 0 is hard-wired: writes to it are dropped and reads return 0.
   assign rs_data = (rs_addr == 5'd0) ? 32'd0 : registers[rs_addr];
   assign rt_data = (rt_addr == 5'd0) ? 32'd0 : registers[rt_addr];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            registers[i] <= 32'd0;
         end
      end else if (we && (wr_addr != 5'd0)) begin
         registers[wr_addr] <= wr_data;
      end
   end
endmodule

// Data memory: asynchronous read, synchronous write, cleared by reset.
// Ports: clk, reset, we - write enable, addr - ALU result byte address,
//        wr_data - store data, rd_data - load data.
module mips_dat_mem (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data
);
`ifdef DMEM_BYTE_EN
   logic [7:0] mem [0:255];
   logic [7:0] a0, a1, a2, a3;
   logic       unused_addr;

   // 8-bit adds make a word that straddles the top of memory wrap to byte 0.
   assign a0 = addr[7:0];
   assign a1 = a0 + 8'd1;
   assign a2 = a0 + 8'd2;
   assign a3 = a0 + 8'd3;
   assign unused_addr = ^addr[31:8];

   assign rd_data = {mem[a3], mem[a2], mem[a1], mem[a0]};

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) begin
            mem[i] <= 8'd0;
         end
      end else if (we) begin
         mem[a0] <= wr_data[7:0];
         mem[a1] <= wr_data[15:8];
         mem[a2] <= wr_data[23:16];
         mem[a3] <= wr_data[31:24];
      end
   end
`else
   logic [31:0] mem [0:255];
   logic [7:0]  widx;
   logic        unused_addr;

   assign widx = addr[9:2];
   assign unused_addr = ^{addr[31:10], addr[1:0]};

   assign rd_data = mem[widx];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) begin
            mem[i] <= 32'd0;
         end
      end else if (we) begin
         mem[widx] <= wr_data;
      end
   end
`endif
endmodule

// Top level: PC, decode, ALU and next-PC selection.
// Ports: clk, reset (synchronous, active-high).
module mips_core (
   input logic clk,
   input logic reset
);
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   logic [31:0] pcout;
   logic [31:0] instruction;

   logic        RegDst, Jump, Branch, MemToReg, MemWrite, ALUSrc, RegWrite;
   logic [1:0]  ALUOp;

   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, wr_reg;
   logic [31:0] imm_ext;
   logic [31:0] rs_data, rt_data, alu_b, alu_result, mem_rd, wr_data;
   logic        zero;
   logic [31:0] pc_plus4, branch_target, jump_target, pc_next;
   logic        unused_shamt;

   assign opcode       = instruction[31:26];
   assign rs           = instruction[25:21];
   assign rt           = instruction[20:16];
   assign rd           = instruction[15:11];
   assign funct        = instruction[5:0];
   assign imm_ext      = {{16{instruction[15]}}, instruction[15:0]};
   assign unused_shamt = ^instruction[10:6];

   // Fetch index wraps modulo 32 words.
   mips_instr_mem instr_mem (
      .addr        (pcout[6:2]),
      .instruction (instruction)
   );

   always_comb begin
      RegDst   = 1'b0;
      Jump     = 1'b0;
      Branch   = 1'b0;
      MemToReg = 1'b0;
      MemWrite = 1'b0;
      ALUSrc   = 1'b0;
      RegWrite = 1'b0;
      ALUOp    = 2'b00;
      case (opcode)
         OP_RTYPE: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            ALUOp    = 2'b10;
         end
         OP_LW: begin
            ALUSrc   = 1'b1;
            MemToReg = 1'b1;
            RegWrite = 1'b1;
         end
         OP_SW: begin
            ALUSrc   = 1'b1;
            MemWrite = 1'b1;
         end
         OP_BEQ: begin
            Branch = 1'b1;
            ALUOp  = 2'b01;
         end
         OP_ADDI: begin
            ALUSrc   = 1'b1;
            RegWrite = 1'b1;
         end
         OP_J: begin
            Jump = 1'b1;
         end
         default: ;
      endcase
   end

   assign wr_reg = RegDst ? rd : rt;

   mips_reg_bank reg_bank (
      .clk     (clk),
      .reset   (reset),
      .we      (RegWrite),
      .rs_addr (rs),
      .rt_addr (rt),
      .wr_addr (wr_reg),
      .wr_data (wr_data),
      .rs_data (rs_data),
      .rt_data (rt_data)
   );

   assign alu_b = ALUSrc ? imm_ext : rt_data;

   // An unrecognised funct still writes its (zero) result to rd.
   always_comb begin
      alu_result = 32'd0;
      case (ALUOp)
         2'b00: alu_result = rs_data + alu_b;
         2'b01: alu_result = rs_data - alu_b;
         2'b10: begin
            case (funct)
               FN_ADD:  alu_result = rs_data + alu_b;
               FN_SUB:  alu_result = rs_data - alu_b;
               FN_AND:  alu_result = rs_data & alu_b;
               FN_OR:   alu_result = rs_data | alu_b;
               FN_SLT:  alu_result = ($signed(rs_data) < $signed(alu_b)) ? 32'd1 : 32'd0;
               default: alu_result = 32'd0;
            endcase
         end
         default: alu_result = 32'd0;
      endcase
   end

   assign zero = (alu_result == 32'd0);

   mips_dat_mem dat_mem (
      .clk     (clk),
      .reset   (reset),
      .we      (MemWrite),
      .addr    (alu_result),
      .wr_data (rt_data),
      .rd_data (mem_rd)
   );

   assign wr_data = MemToReg ? mem_rd : alu_result;

   assign pc_plus4      = pcout + 32'd4;
   assign branch_target = pc_plus4 + {imm_ext[29:0], 2'b00};
   assign jump_target   = {pc_plus4[31:28], instruction[25:0], 2'b00};

   always_comb begin
      pc_next = pc_plus4;
      if (Jump) begin
         pc_next = jump_target;
      end else if (Branch && zero) begin
         pc_next = branch_target;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pcout <= 32'd0;
      end else begin
         pcout <= pc_next;
      end
   end
endmodule

// File: tb/tb_mips_core.sv
// tb/tb_mips_core.sv - directed self-checking bench for mips_core
module tb_mips_core;
   logic clk;
   logic reset;
   int   total;
   int   bad;

   mips_core dut (
      .clk   (clk),
      .reset (reset)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] enc_j(input logic [25:0] target);
      return {6'h02, target};
   endfunction

   function automatic logic [31:0] dword(input int a);
      logic [31:0] av;
      logic [7:0]  b;
      av = a;
      b  = av[7:0];
`ifdef DMEM_BYTE_EN
      return {dut.dat_mem.mem[b + 8'd3], dut.dat_mem.mem[b + 8'd2],
              dut.dat_mem.mem[b + 8'd1], dut.dat_mem.mem[b]};
`else
      b = av[9:2];
      return dut.dat_mem.mem[b];
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic fill_nop();
      for (int i = 0; i < 32; i++) dut.instr_mem.mem[i] = 32'hFFFF_FFFF;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;

      // ALU program
      fill_nop();
      dut.instr_mem.mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'd5);
      dut.instr_mem.mem[1]  = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);
      dut.instr_mem.mem[2]  = enc_r(5'd1, 5'd2, 5'd3, 6'h20);
      dut.instr_mem.mem[3]  = enc_r(5'd1, 5'd2, 5'd4, 6'h22);
      dut.instr_mem.mem[4]  = enc_r(5'd1, 5'd2, 5'd7, 6'h24);
      dut.instr_mem.mem[5]  = enc_r(5'd1, 5'd2, 5'd8, 6'h25);
      dut.instr_mem.mem[6]  = enc_r(5'd2, 5'd1, 5'd5, 6'h2A);
      dut.instr_mem.mem[7]  = enc_i(6'h08, 5'd0, 5'd9, 16'd7);
      dut.instr_mem.mem[8]  = enc_r(5'd1, 5'd2, 5'd9, 6'h27);
      dut.instr_mem.mem[9]  = enc_i(6'h08, 5'd0, 5'd14, 16'hFFFF);
      dut.instr_mem.mem[10] = enc_r(5'd14, 5'd1, 5'd15, 6'h20);
      dut.instr_mem.mem[11] = enc_r(5'd1, 5'd2, 5'd13, 6'h2A);

      // Two reset cycles with an addi at PC 0: nothing may be written.
      step();
      step();
      check("reset_pc", dut.pcout, 32'd0);
      for (int i = 0; i < 32; i++) check($sformatf("reset_reg%0d", i), dut.reg_bank.registers[i], 32'd0);
      for (int i = 0; i < 256; i++) check($sformatf("reset_mem%0d", i), 32'(dut.dat_mem.mem[i]), 32'd0);

      reset = 1'b0;
      check("rel_pc0", dut.pcout, 32'd0);
      check("addi_regwrite", 32'(dut.RegWrite), 32'd1);
      check("addi_alusrc", 32'(dut.ALUSrc), 32'd1);
      check("addi_aluop", 32'(dut.ALUOp), 32'd0);
      step();
      check("rel_pc4", dut.pcout, 32'd4);
      check("r1_5", dut.reg_bank.registers[1], 32'd5);
      step();
      check("rel_pc8", dut.pcout, 32'd8);
      check("r2_m3", dut.reg_bank.registers[2], 32'hFFFF_FFFD);
      check("add_aluop", 32'(dut.ALUOp), 32'd2);
      check("add_regdst", 32'(dut.RegDst), 32'd1);
      check("add_alusrc", 32'(dut.ALUSrc), 32'd0);
      step();
      check("r3_add", dut.reg_bank.registers[3], 32'd2);
      check("sub_aluop", 32'(dut.ALUOp), 32'd2);
      step();
      check("r4_sub", dut.reg_bank.registers[4], 32'd8);
      step();
      check("r7_and", dut.reg_bank.registers[7], 32'd5);
      step();
      check("r8_or", dut.reg_bank.registers[8], 32'hFFFF_FFFD);
      step();
      check("r5_slt", dut.reg_bank.registers[5], 32'd1);
      step();
      check("r9_7", dut.reg_bank.registers[9], 32'd7);
      check("unk_fn_regwrite", 32'(dut.RegWrite), 32'd1);
      step();
      check("r9_unk_fn", dut.reg_bank.registers[9], 32'd0);
      step();
      check("r14_m1", dut.reg_bank.registers[14], 32'hFFFF_FFFF);
      step();
      check("r15_wrap", dut.reg_bank.registers[15], 32'd4);
      step();
      check("r13_slt0", dut.reg_bank.registers[13], 32'd0);
      check("pc_48", dut.pcout, 32'd48);

      // Memory and control-flow program
      reset = 1'b1;
      fill_nop();
      dut.instr_mem.mem[0]  = enc_i(6'h08, 5'd0, 5'd1, 16'h0077);
      dut.instr_mem.mem[1]  = enc_i(6'h2B, 5'd0, 5'd1, 16'd8);
      dut.instr_mem.mem[2]  = enc_i(6'h23, 5'd0, 5'd6, 16'd8);
      dut.instr_mem.mem[3]  = enc_r(5'd6, 5'd6, 5'd10, 6'h20);
      dut.instr_mem.mem[4]  = enc_i(6'h04, 5'd0, 5'd0, 16'd2);
      dut.instr_mem.mem[5]  = enc_i(6'h08, 5'd0, 5'd11, 16'd1);
      dut.instr_mem.mem[6]  = enc_i(6'h08, 5'd0, 5'd11, 16'd2);
      dut.instr_mem.mem[7]  = enc_i(6'h04, 5'd1, 5'd0, 16'd5);
      dut.instr_mem.mem[8]  = enc_i(6'h08, 5'd0, 5'd0, 16'd9);
      dut.instr_mem.mem[9]  = 32'hFFFF_FFFF;
      dut.instr_mem.mem[10] = enc_i(6'h08, 5'd0, 5'd12, 16'd7);
      dut.instr_mem.mem[11] = enc_r(5'd1, 5'd1, 5'd12, 6'h27);
      dut.instr_mem.mem[12] = enc_j(26'd4);
      do_reset();
      check("b_reset_r2", dut.reg_bank.registers[2], 32'd0);
      check("b_pc0", dut.pcout, 32'd0);
      check("b_memwrite_addi", 32'(dut.MemWrite), 32'd0);
      step();
      check("b_r1_77", dut.reg_bank.registers[1], 32'h77);
      check("sw_memwrite", 32'(dut.MemWrite), 32'd1);
      check("sw_regwrite", 32'(dut.RegWrite), 32'd0);
      check("sw_alusrc", 32'(dut.ALUSrc), 32'd1);
      step();
      check("sw_mem8", dword(8), 32'h77);
`ifdef DMEM_BYTE_EN
      check("sw_byte8", 32'(dut.dat_mem.mem[8]), 32'h77);
      check("sw_byte9", 32'(dut.dat_mem.mem[9]), 32'h00);
`else
      check("sw_word2", 32'(dut.dat_mem.mem[2]), 32'h77);
`endif
      check("lw_memwrite", 32'(dut.MemWrite), 32'd0);
      check("lw_memtoreg", 32'(dut.MemToReg), 32'd1);
      step();
      check("lw_r6", dut.reg_bank.registers[6], 32'h77);
      step();
      check("dep_r10", dut.reg_bank.registers[10], 32'hEE);
      check("beq_pc16", dut.pcout, 32'd16);
      check("beq_branch", 32'(dut.Branch), 32'd1);
      check("beq_aluop", 32'(dut.ALUOp), 32'd1);
      step();
      check("beq_taken_pc", dut.pcout, 32'd28);
      check("beq2_branch", 32'(dut.Branch), 32'd1);
      step();
      check("beq_not_taken_pc", dut.pcout, 32'd32);
      check("skip_r11", dut.reg_bank.registers[11], 32'd0);
      step();
      check("r0_protect", dut.reg_bank.registers[0], 32'd0);
      check("nop_regwrite", 32'(dut.RegWrite), 32'd0);
      check("nop_memwrite", 32'(dut.MemWrite), 32'd0);
      check("nop_jump", 32'(dut.Jump), 32'd0);
      check("nop_branch", 32'(dut.Branch), 32'd0);
      step();
      check("nop_pc40", dut.pcout, 32'd40);
      check("nop_r1", dut.reg_bank.registers[1], 32'h77);
      check("nop_mem8", dword(8), 32'h77);
      step();
      check("r12_7", dut.reg_bank.registers[12], 32'd7);
      step();
      check("r12_unk", dut.reg_bank.registers[12], 32'd0);
      check("j_jump", 32'(dut.Jump), 32'd1);
      check("j_regwrite", 32'(dut.RegWrite), 32'd0);
      step();
      check("j_pc16", dut.pcout, 32'd16);

      // Reset asserted during a store
      reset = 1'b1;
      fill_nop();
      dut.instr_mem.mem[0] = enc_i(6'h08, 5'd0, 5'd1, 16'h0055);
      dut.instr_mem.mem[1] = enc_i(6'h2B, 5'd0, 5'd1, 16'd16);
      do_reset();
      step();
      check("c_r1_55", dut.reg_bank.registers[1], 32'h55);
      check("c_sw_memwrite", 32'(dut.MemWrite), 32'd1);
      reset = 1'b1;
      step();
      check("mid_pc0", dut.pcout, 32'd0);
      check("mid_r1", dut.reg_bank.registers[1], 32'd0);
      check("mid_mem16", dword(16), 32'd0);
      check("mid_r6", dut.reg_bank.registers[6], 32'd0);
      reset = 1'b0;
      check("mid_rel_pc0", dut.pcout, 32'd0);
      step();
      check("mid_rel_pc4", dut.pcout, 32'd4);
      step();
      check("mid_rel_pc8", dut.pcout, 32'd8);
      check("mid_store", dword(16), 32'h55);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mips_core.md
# mips_core

Single-cycle 32-bit MIPS subset processor: program counter, 32-word instruction memory, 32×32 register file, 256-entry data memory, main control and ALU control. The top-level core the verification environment drives. The bench loads programs by writing instruction memory hierarchically and checks architectural state through internal signals.

## Interface
- No parameters.
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Observable internals (fixed hierarchical names):
  - instruction[31:0], pcout[31:0]
  - control: RegDst, Jump, Branch, MemToReg, MemWrite, ALUSrc, RegWrite, ALUOp[1:0]
  - instr_mem.mem[0:31] (32-bit; written only by the bench)
  - reg_bank.registers[0:31] (32-bit)
  - dat_mem.mem[0:255]

## Operation
- Fetch: instruction = instr_mem.mem[pcout[6:2]]. The index wraps modulo 32.
- Decode by opcode [31:26]. Unlisted control signals are 0.
  - 0x00 R-type: RegDst=1, RegWrite=1, ALUOp=10.
  - 0x23 lw: ALUSrc=1, MemToReg=1, RegWrite=1, ALUOp=00.
  - 0x2B sw: ALUSrc=1, MemWrite=1, ALUOp=00.
  - 0x04 beq: Branch=1, ALUOp=01.
  - 0x08 addi: ALUSrc=1, RegWrite=1, ALUOp=00.
  - 0x02 j: Jump=1.
  - Any other opcode is a NOP: all controls 0, PC+4.
- ALU control:
  - ALUOp 00 → add; ALUOp 01 → subtract.
  - ALUOp 10 uses funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 1/0).
  - Unknown funct → result 0, but the register write still occurs.
  - Arithmetic wraps at 32 bits; no overflow trap.
- Operands:
  - Immediate is sign-extended [15:0].
  - Write register is rd when RegDst=1, else rt.
  - Writes to register 0 are discarded; register 0 always reads 0.
- Register file: asynchronous read, synchronous write.
- Next PC:
  - Jump → {PC+4[31:28], instr[25:0], 2'b00}.
  - Branch and zero → PC+4 + (signext imm << 2).
  - Otherwise → PC+4.
- Data memory (word-organised default): 256 × 32-bit, addressed by ALU result [9:2]. Asynchronous read, synchronous write.

## Timing
- One instruction retires per clock; control and instruction are combinational from pcout.
- At each rising edge with reset=0: PC, the destination register and the memory word all update together.
- At a rising edge with reset=1:
  - pcout ← 0, all registers ← 0, all data memory entries ← 0.
  - Register and memory writes requested by the current instruction are suppressed.
- Reset asserted mid-program takes effect at the next edge. Execution restarts at address 0 on the first edge after deassertion.
- lw followed immediately by a dependent instruction sees the loaded value (single-cycle, no hazards).
- sw then lw to the same address in consecutive cycles returns the stored value.

## Configuration
- DMEM_BYTE_EN undefined: dat_mem.mem is 256 × 32-bit words, as above.
- DMEM_BYTE_EN defined:
  - dat_mem.mem is 256 × 8-bit bytes, indexed by ALU result [7:0].
  - lw/sw access 4 consecutive bytes, little-endian (byte at addr is bits [7:0]), and wrap within 256.
  - Misaligned addresses are permitted and not trapped.

## Test plan
- Reset: hold reset 2 cycles → pcout=0, all registers 0, all memory 0, no writes; after release pcout steps 0,4,8.
- ALU program `addi $1,$0,5`; `addi $2,$0,-3`; `add $3,$1,$2`; `sub $4,$1,$2`; `and`/`or`/`slt $5,$2,$1` → $3=2, $4=8, $5=1. ALUOp=10 on R-type cycles.
- Memory: `addi $1,$0,0x77`; `sw $1,8($0)`; `lw $6,8($0)` → word index 2 (or bytes 8..11 with DMEM_BYTE_EN) = 0x77, $6=0x77. MemWrite=1 only in the sw cycle.
- Control flow: `beq $0,$0,+2` at PC 0 → next PC 12; taken/not-taken both checked. `j 0x4` → PC 16. Jump=1 / Branch=1 in the respective cycles.
- $0 protection and unknown opcode: `addi $0,$0,9` leaves $0=0; opcode 0x3F changes nothing except PC+4.
- Reset mid-program: assert reset during a sw cycle → store suppressed, state cleared, pcout=0.
